// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// WIDTH iterations per operation followed by a sign-fix cycle and a one-cycle done pulse.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [1:0]           op_r;
  logic                 sa_r, sb_r;
  logic [WIDTH-1:0]     ma_r, mb_r;
  logic [2*WIDTH-1:0]   p_r;
  logic                 busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   p_next_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     fix_hi_s, fix_lo_s;
  logic                 fix_dbz_s;

  // One iteration: p_r holds {acc, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum_s   = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, ma_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mb_r};
    p_next_s    = p_r;
    if (op_r[1]) begin
      if (!div_diff_s[WIDTH]) begin
        p_next_s = {div_diff_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
      end else begin
        p_next_s = {div_shift_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      p_next_s = {mul_sum_s, p_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result; a zero divisor forces an all-ones quotient
  always_comb begin
    prod_s    = p_r;
    fix_hi_s  = p_r[2*WIDTH-1:WIDTH];
    fix_lo_s  = p_r[WIDTH-1:0];
    fix_dbz_s = 1'b0;
    if (op_r[1]) begin
      fix_dbz_s = (mb_r == {WIDTH{1'b0}});
      if (sa_r) begin
        fix_hi_s = neg_w(p_r[2*WIDTH-1:WIDTH]);
      end else begin
        fix_hi_s = p_r[2*WIDTH-1:WIDTH];
      end
      if (fix_dbz_s) begin
        fix_lo_s = {WIDTH{1'b1}};
      end else if (sa_r ^ sb_r) begin
        fix_lo_s = neg_w(p_r[WIDTH-1:0]);
      end else begin
        fix_lo_s = p_r[WIDTH-1:0];
      end
    end else begin
      if (sa_r ^ sb_r) begin
        prod_s = neg_2w(p_r);
      end else begin
        prod_s = p_r;
      end
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= 2'b00;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      ma_r    <= {WIDTH{1'b0}};
      mb_r    <= {WIDTH{1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r    <= op;
            sa_r    <= op[0] & a[WIDTH-1];
            sb_r    <= op[0] & b[WIDTH-1];
            ma_r    <= (op[0] & a[WIDTH-1]) ? neg_w(a) : a;
            mb_r    <= (op[0] & b[WIDTH-1]) ? neg_w(b) : b;
            p_r     <= {{WIDTH{1'b0}}, op[1] ? ((op[0] & a[WIDTH-1]) ? neg_w(a) : a)
                                             : ((op[0] & b[WIDTH-1]) ? neg_w(b) : b)};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          p_r   <= p_next_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          dbz_r   <= fix_dbz_s;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq (WIDTH=32): vector table plus hand-written
// sequences for ignored start, back-to-back start and mid-operation reset.
module tb_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_cnt = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation and let it be accepted at the next rising edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~o;
  endtask

  // Wait (bounded) for done and check latency, results, busy length and hold.
  task automatic finish(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz);
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " done_seen"}, {63'd0, done}, 64'd1);
    chk({name, " latency"}, 64'(cyc - acc_cyc), 64'd33);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, elo});
    chk({name, " dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
    @(posedge clk);
    #1;
    chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd34);
    chk({name, " after_done"}, {62'd0, busy, done}, 64'd0);
    chk({name, " hold_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int dones;
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    #12;
    chk("reset_state", {29'd0, busy, done, div_by_zero, hi, 2'b00}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Each vector starts in the first idle cycle after the previous done.
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy_on_accept", i), {63'd0, busy}, 64'd1);
      finish($sformatf("v%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dbz);
    end

    // A second start during CALC must be ignored.
    launch(2'b00, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish("ignored_start", 32'd0, 32'd63, 1'b0);

    // Reset between edges during CALC drops outputs at once; no done follows.
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midcalc_reset ctl", {62'd0, busy, done}, 64'd0);
    chk("midcalc_reset hi", {32'd0, hi}, 64'd0);
    chk("midcalc_reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("no_done_after_reset", 64'(dones), 64'd0);

    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish("post_reset", 32'd0, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted rst=0 forces reset state immediately.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  WIDTH  multiplicand/dividend, captured with start.
REQ-007 b  input  WIDTH  multiplier/divisor, captured with start.
REQ-008 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-009 done  output  1  single-cycle pulse; hi/lo/div_by_zero valid in that cycle.
REQ-010 hi  output  WIDTH  product upper half, or remainder.
REQ-011 lo  output  WIDTH  product lower half, or quotient.
REQ-012 div_by_zero  output  1  registered flag, valid with done, held until next done.

Function
REQ-013 FSM states IDLE, CALC, FIX, DONE; busy=1 in CALC, FIX, DONE.
REQ-014 IDLE: start=1 at edge k -> capture a, b, op; store operand magnitudes and sign bits for signed ops; clear iteration counter; go to CALC.
REQ-015 CALC: one radix-2 step per edge (shift-add multiply; restoring divide on magnitudes); exactly WIDTH steps; after the step at edge k+WIDTH, go to FIX.
REQ-016 FIX, edge k+WIDTH+1: apply sign correction; register hi, lo and div_by_zero; go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, between edges k+WIDTH+1 and k+WIDTH+2; next edge returns to IDLE.
REQ-018 Throughput: a start in the cycle after DONE is accepted; start in CALC/FIX/DONE is ignored with no queuing.
REQ-019 Multiply: 2*WIDTH-bit product {hi,lo}; MULT negates the magnitude product when sign(a) XOR sign(b).
REQ-020 Divide: quotient truncates toward zero; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (DIV only).
REQ-021 DIV with a = most-negative, b = -1: lo = most-negative value (wraps), hi = 0; div_by_zero = 0.
REQ-022 Divide with b = 0: full latency still taken; lo = all ones, hi = a unchanged, div_by_zero = 1.
REQ-023 Multiply ops: div_by_zero = 0 on done.
REQ-024 hi, lo, div_by_zero change only at the FIX->DONE edge; they hold between operations.
REQ-025 Counter width is clog2(WIDTH)+1 bits; no wrap within an operation.
REQ-026 Changes on a, b or op after acceptance do not affect the running operation.

Reset
REQ-027 rst=0 at any time, including mid-CALC: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, operand registers=0.
REQ-028 First start is accepted at the first rising edge with rst=1 and start=1; the in-flight operation is discarded.

Verification (WIDTH=32)
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 edges after the accepting edge; hi=0xFFFFFFFE, lo=0x00000001; busy high 34 cycles.
REQ-030 MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
REQ-032 DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1; a following MULTU 2*3 -> hi=0, lo=6, div_by_zero=0.
REQ-033 start pulsed again at CALC iteration 5 with different operands -> ignored; results match the first operation; back-to-back start in the cycle after done is accepted.
REQ-034 rst driven low between edges during CALC iteration 10 -> busy, done, hi, lo drop to 0 without a clock edge; no done pulse follows release.
